// File: rtl/pipelined_adder_alu_pkg.sv
`default_nettype none
// ============================================================================
// Package : alu_pkg
// Mode encodings and result-flag bundle shared by the pipelined add/sub unit.
// Rev     : 1.0
// ============================================================================
package alu_pkg;

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_ADC = 2'b10,
        MODE_SBB = 2'b11
    } alu_mode_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic negative;
        logic overflow;
    } alu_flags_t;

endpackage
`default_nettype wire

// File: rtl/pipelined_adder_alu_if.sv
`default_nettype none
// ============================================================================
// Interface : pipelined_adder_alu_if
// Operand/result valid-ready bus; in_sat exists only when ADDER_SAT_EN is set.
// Rev       : 1.0
// ============================================================================
interface pipelined_adder_alu_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_op1;
    logic [WIDTH-1:0] in_op2;
    logic [1:0]       in_mode;
    logic             in_cin;
`ifdef ADDER_SAT_EN
    logic             in_sat;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_carry;
    logic             out_zero;
    logic             out_negative;
    logic             out_overflow;

    modport master (
        output in_valid, in_op1, in_op2, in_mode, in_cin,
`ifdef ADDER_SAT_EN
        output in_sat,
`endif
        output out_ready,
        input  in_ready, out_valid, out_result, out_carry, out_zero,
        input  out_negative, out_overflow
    );

    modport slave (
        input  in_valid, in_op1, in_op2, in_mode, in_cin,
`ifdef ADDER_SAT_EN
        input  in_sat,
`endif
        input  out_ready,
        output in_ready, out_valid, out_result, out_carry, out_zero,
        output out_negative, out_overflow
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_adder_alu_adder_slice.sv
`default_nettype none
// ============================================================================
// Module : adder_slice
// Combinational CHUNK-bit ripple-carry slice; also exposes carry into its msb.
// Rev    : 1.0
// ============================================================================
module adder_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);
    logic [CHUNK:0] w_c;

    always_comb begin
        w_c    = '0;
        sum    = '0;
        w_c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]   = a[i] ^ b[i] ^ w_c[i];
            w_c[i+1] = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
        end
    end

    assign cout     = w_c[CHUNK];
    assign c_msb_in = w_c[CHUNK-1];
endmodule
`default_nettype wire

// File: rtl/pipelined_adder_alu.sv
`default_nettype none
// ============================================================================
// Module : pipelined_adder_alu
// STAGES-deep ripple add/sub (ADD/SUB/ADC/SBB) with C/Z/N/V; ADDER_SAT_EN clamps.
// Rev    : 1.0
// ============================================================================
module pipelined_adder_alu
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    pipelined_adder_alu_if.slave bus
);
    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    logic [STAGES-1:0][WIDTH-1:0] w_a_in, w_b_in, w_s_in, w_s_nxt;
    logic [STAGES-1:0]            w_c_in, w_c_nxt, w_cm_nxt, w_v_in, w_sat_in, w_load;

    logic [STAGES-1:0][WIDTH-1:0] r_a, r_b, r_s;
    logic [STAGES-1:0]            r_c, r_cm, r_valid, r_sat;

    logic [WIDTH-1:0] w_b0;
    logic             w_c0;
    logic             w_sat0;

    always_comb begin
        w_b0 = bus.in_op2;
        w_c0 = 1'b0;
        case (alu_mode_e'(bus.in_mode))
            MODE_ADD: ;
            MODE_SUB: begin w_b0 = ~bus.in_op2; w_c0 = 1'b1;       end
            MODE_ADC: begin                     w_c0 = bus.in_cin; end
            MODE_SBB: begin w_b0 = ~bus.in_op2; w_c0 = bus.in_cin; end
            default:  ;
        endcase
    end

`ifdef ADDER_SAT_EN
    assign w_sat0 = bus.in_sat;
`else
    assign w_sat0 = 1'b0;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK-1:0] w_sum;
        logic             w_cout;
        logic             w_cm;

        if (k == 0) begin : g_head
            assign w_a_in[k]   = bus.in_op1;
            assign w_b_in[k]   = w_b0;
            assign w_s_in[k]   = '0;
            assign w_c_in[k]   = w_c0;
            assign w_v_in[k]   = bus.in_valid;
            assign w_sat_in[k] = w_sat0;
        end else begin : g_body
            assign w_a_in[k]   = r_a[k-1];
            assign w_b_in[k]   = r_b[k-1];
            assign w_s_in[k]   = r_s[k-1];
            assign w_c_in[k]   = r_c[k-1];
            assign w_v_in[k]   = r_valid[k-1];
            assign w_sat_in[k] = r_sat[k-1];
        end

        adder_slice #(.CHUNK(CHUNK)) u_slice (
            .a        (w_a_in[k][k*CHUNK +: CHUNK]),
            .b        (w_b_in[k][k*CHUNK +: CHUNK]),
            .cin      (w_c_in[k]),
            .sum      (w_sum),
            .cout     (w_cout),
            .c_msb_in (w_cm)
        );

        // Bits above this slice are still zero in the partial sum, so OR merges.
        assign w_s_nxt[k]  = w_s_in[k] | (WIDTH'(w_sum) << (k * CHUNK));
        assign w_c_nxt[k]  = w_cout;
        assign w_cm_nxt[k] = w_cm;

        // A stage can load if it or any stage downstream of it has a hole.
        assign w_load[k] = bus.out_ready | ~(&r_valid[LAST:k]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_c     <= '0;
            r_cm    <= '0;
            r_sat   <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_load[k]) begin
                    r_valid[k] <= w_v_in[k];
                    r_a[k]     <= w_a_in[k];
                    r_b[k]     <= w_b_in[k];
                    r_s[k]     <= w_s_nxt[k];
                    r_c[k]     <= w_c_nxt[k];
                    r_cm[k]    <= w_cm_nxt[k];
                    r_sat[k]   <= w_sat_in[k];
                end
            end
        end
    end

    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    alu_flags_t       w_flags;

    assign w_ovf = r_cm[LAST] ^ r_c[LAST];

    always_comb begin
        w_res = r_s[LAST];
        if (r_sat[LAST] && w_ovf) begin
            w_res = r_a[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
        end
        if (!r_valid[LAST]) begin
            w_res = '0;
        end
        w_flags.carry    = r_valid[LAST] & r_c[LAST];
        w_flags.zero     = r_valid[LAST] & (w_res == '0);
        w_flags.negative = w_res[WIDTH-1];
        w_flags.overflow = r_valid[LAST] & w_ovf;
    end

    assign bus.in_ready     = w_load[0];
    assign bus.out_valid    = r_valid[LAST];
    assign bus.out_result   = w_res;
    assign bus.out_carry    = w_flags.carry;
    assign bus.out_zero     = w_flags.zero;
    assign bus.out_negative = w_flags.negative;
    assign bus.out_overflow = w_flags.overflow;
endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder_alu.sv
`default_nettype none
// ============================================================================
// Module : tb_pipelined_adder_alu
// Directed self-checking bench for pipelined_adder_alu (WIDTH=32, STAGES=4).
// Rev    : 1.0
// ============================================================================
module tb_pipelined_adder_alu;
    import alu_pkg::*;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pipelined_adder_alu_if #(.WIDTH(32)) bus ();

    pipelined_adder_alu #(.WIDTH(32), .STAGES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.in_op1   = $urandom;
        bus.in_op2   = $urandom;
        bus.in_mode  = 2'($urandom);
        bus.in_cin   = 1'($urandom);
`ifdef ADDER_SAT_EN
        bus.in_sat   = 1'($urandom);
`endif
    endtask

    function automatic logic [3:0] flags_now();
        return {bus.out_carry, bus.out_zero, bus.out_negative, bus.out_overflow};
    endfunction

    // Issues one beat and waits (bounded) for it to appear; lat=-1 on timeout.
    task automatic run_beat(input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] m, input logic cin,
                            output logic [31:0] res, output logic [3:0] fl,
                            output int lat);
        int w;
        bus.in_op1   = a;
        bus.in_op2   = b;
        bus.in_mode  = m;
        bus.in_cin   = cin;
        bus.in_valid = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 20) begin
            tick();
            w++;
        end
        tick();
        idle_inputs();
        res = '0;
        fl  = '0;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid) begin
                lat = i;
                res = bus.out_result;
                fl  = flags_now();
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.out_ready = 1'b1;
        idle_inputs();
        repeat (3) tick();
        rst = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        n_checks++;
        if (bus.out_result !== 32'h0) begin
            n_fail++; $display("FAIL reset_result: got %h expected 00000000", bus.out_result);
        end
        n_checks++;
        if (flags_now() !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 0000", flags_now());
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_add();
        logic [31:0] res; logic [3:0] fl; int lat;
        run_beat(32'h0000_0005, 32'h0000_0003, MODE_ADD, 1'b0, res, fl, lat);
        n_checks++;
        if (lat !== LAT) begin n_fail++; $display("FAIL add_latency: got %0d expected %0d", lat, LAT); end
        n_checks++;
        if (res !== 32'h0000_0008) begin n_fail++; $display("FAIL add_result: got %h expected 00000008", res); end
        n_checks++;
        if (fl !== 4'b0000) begin n_fail++; $display("FAIL add_flags: got %b expected 0000", fl); end
        run_beat(32'h7FFF_FFFF, 32'h0000_0001, MODE_ADD, 1'b0, res, fl, lat);
        n_checks++;
        if (res !== 32'h8000_0000) begin n_fail++; $display("FAIL add_wrap_result: got %h expected 80000000", res); end
        n_checks++;
        if (fl !== 4'b0011) begin n_fail++; $display("FAIL add_wrap_flags: got %b expected 0011", fl); end
    endtask

    task automatic test_sub();
        logic [31:0] res; logic [3:0] fl; int lat;
        run_beat(32'h0000_0003, 32'h0000_0005, MODE_SUB, 1'b1, res, fl, lat);
        n_checks++;
        if (res !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sub_neg_result: got %h expected fffffffe", res); end
        n_checks++;
        if (fl !== 4'b0010) begin n_fail++; $display("FAIL sub_neg_flags: got %b expected 0010", fl); end
        run_beat(32'h8000_0000, 32'h0000_0001, MODE_SUB, 1'b0, res, fl, lat);
        n_checks++;
        if (res !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL sub_ovf_result: got %h expected 7fffffff", res); end
        n_checks++;
        if (fl !== 4'b1001) begin n_fail++; $display("FAIL sub_ovf_flags: got %b expected 1001", fl); end
    endtask

    task automatic test_chain();
        logic [31:0] res; logic [3:0] fl; int lat;
        run_beat(32'hFFFF_FFFF, 32'h0000_0001, MODE_ADC, 1'b0, res, fl, lat);
        n_checks++;
        if (res !== 32'h0) begin n_fail++; $display("FAIL adc_zero_result: got %h expected 00000000", res); end
        n_checks++;
        if (fl !== 4'b1100) begin n_fail++; $display("FAIL adc_zero_flags: got %b expected 1100", fl); end
        run_beat(32'h0000_0001, 32'h0000_0002, MODE_ADC, 1'b1, res, fl, lat);
        n_checks++;
        if (res !== 32'h4 || fl !== 4'b0000) begin
            n_fail++; $display("FAIL adc_cin_result: got %h/%b expected 00000004/0000", res, fl);
        end
        run_beat(32'h0000_0005, 32'h0000_0002, MODE_SBB, 1'b0, res, fl, lat);
        n_checks++;
        if (res !== 32'h2 || fl !== 4'b1000) begin
            n_fail++; $display("FAIL sbb_borrow_result: got %h/%b expected 00000002/1000", res, fl);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va   [8] = '{32'h1, 32'hA, 32'hFFFF_0000, 32'h0, 32'h10, 32'h100, 32'h1234_5678, 32'h50};
        logic [31:0] vb   [8] = '{32'h2, 32'h4, 32'h0001_FFFF, 32'h1, 32'h20, 32'h1,   32'h1111_1111, 32'h50};
        logic [1:0]  vm   [8] = '{MODE_ADD, MODE_SUB, MODE_ADD, MODE_SUB, MODE_ADC, MODE_SBB, MODE_ADD, MODE_SUB};
        logic        vc   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] vexp [8] = '{32'h3, 32'h6, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'h31, 32'hFF, 32'h2345_6789, 32'h0};
        int          sent = 0, recv = 0, cyc = 0, first_block = -1, stable_err = 0, dup = 0, buffered;
        logic        prev_stall = 1'b0;
        logic [31:0] prev_res   = '0;
        while (recv < 8 && cyc < 60) begin
            bus.out_ready = !(cyc >= 3 && cyc <= 9);
            if (sent < 8) begin
                bus.in_valid = 1'b1;
                bus.in_op1   = va[sent];
                bus.in_op2   = vb[sent];
                bus.in_mode  = vm[sent];
                bus.in_cin   = vc[sent];
            end else begin
                idle_inputs();
            end
            #1;
            buffered = sent - recv;
            if (prev_stall && bus.out_result !== prev_res) stable_err++;
            if (!bus.in_ready && bus.in_valid && first_block < 0) first_block = buffered;
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                if (bus.out_result !== vexp[recv]) begin
                    n_fail++;
                    $display("FAIL b2b_result[%0d]: got %h expected %h", recv, bus.out_result, vexp[recv]);
                end
                recv++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_res   = bus.out_result;
            if (bus.in_valid && bus.in_ready) sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.out_ready = 1'b1;
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            if (bus.out_valid) dup++;
            tick();
        end
        n_checks++;
        if (recv !== 8 || sent !== 8) begin
            n_fail++; $display("FAIL b2b_count: got sent=%0d recv=%0d expected 8/8", sent, recv);
        end
        n_checks++;
        if (first_block !== 4) begin
            n_fail++; $display("FAIL b2b_in_ready_fall: got %0d buffered expected 4", first_block);
        end
        n_checks++;
        if (stable_err !== 0) begin
            n_fail++; $display("FAIL b2b_stall_stable: got %0d changes expected 0", stable_err);
        end
        n_checks++;
        if (dup !== 0) begin
            n_fail++; $display("FAIL b2b_no_dup: got %0d extra beats expected 0", dup);
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] res; logic [3:0] fl; int lat; int seen = 0;
        bus.in_valid = 1'b1; bus.in_op1 = 32'h1; bus.in_op2 = 32'h1; bus.in_mode = MODE_ADD; bus.in_cin = 1'b0;
        tick();
        bus.in_op1 = 32'h2; bus.in_op2 = 32'h2;
        tick();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid || bus.out_result !== 32'h0 || flags_now() !== 4'b0000) seen++;
            tick();
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL midreset_quiet: got %0d active cycles expected 0", seen); end
        run_beat(32'h0000_1234, 32'h0000_4321, MODE_ADD, 1'b0, res, fl, lat);
        n_checks++;
        if (res !== 32'h0000_5555 || lat !== LAT) begin
            n_fail++; $display("FAIL midreset_next_beat: got %h lat %0d expected 00005555 lat %0d", res, lat, LAT);
        end
    endtask

`ifdef ADDER_SAT_EN
    task automatic test_sat();
        logic [31:0] res; logic [3:0] fl; int lat;
        bus.in_sat = 1'b1;
        run_beat(32'h7FFF_FFFF, 32'h0000_0001, MODE_ADD, 1'b0, res, fl, lat);
        n_checks++;
        if (res !== 32'h7FFF_FFFF || fl !== 4'b0001) begin
            n_fail++; $display("FAIL sat_add: got %h/%b expected 7fffffff/0001", res, fl);
        end
        bus.in_sat = 1'b1;
        run_beat(32'h8000_0000, 32'h0000_0001, MODE_SUB, 1'b0, res, fl, lat);
        n_checks++;
        if (res !== 32'h8000_0000 || fl !== 4'b1011) begin
            n_fail++; $display("FAIL sat_sub: got %h/%b expected 80000000/1011", res, fl);
        end
        bus.in_sat = 1'b0;
        run_beat(32'h7FFF_FFFF, 32'h0000_0001, MODE_ADD, 1'b0, res, fl, lat);
        n_checks++;
        if (res !== 32'h8000_0000 || fl !== 4'b0011) begin
            n_fail++; $display("FAIL nosat_add: got %h/%b expected 80000000/0011", res, fl);
        end
        bus.in_sat = 1'b0;
        run_beat(32'h8000_0000, 32'h0000_0001, MODE_SUB, 1'b0, res, fl, lat);
        n_checks++;
        if (res !== 32'h7FFF_FFFF || fl !== 4'b1001) begin
            n_fail++; $display("FAIL nosat_sub: got %h/%b expected 7fffffff/1001", res, fl);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.out_ready = 1'b1;
        idle_inputs();
        tick();
        test_reset();
        test_add();
        test_sub();
        test_chain();
        test_back_to_back();
        test_mid_reset();
`ifdef ADDER_SAT_EN
        test_sat();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
